// File: rtl/float_to_int.sv
// float_to_int: IEEE-754 binary32 -> saturating signed OUT_WIDTH integer.
// Two-stage pipeline, one operand per clock, no backpressure.
// Optional build macro FLOAT_TO_INT_ROUND_EN: round to nearest, ties away
// from zero (default truncates toward zero).
module float_to_int #(
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [31:0]          floatin,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] intout
);

  localparam int STAGES = 2;
  localparam logic [OUT_WIDTH-1:0] MAXV = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MINV = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  // Biased exponent at which |x| >= 2^(OUT_WIDTH-1) and the result pins.
  localparam logic [7:0] EXP_SAT = 8'(127 + OUT_WIDTH - 1);

  // Stage-1 record: zero collapses zero/denormal/NaN/underflow,
  // sat collapses infinity/overflow.
  typedef struct packed {
    logic                 sign;
    logic                 zero;
    logic                 sat;
    logic [OUT_WIDTH-1:0] mag;
  } s1_t;

  logic [7:0]           exp;
  logic [22:0]          frac;
  logic [4:0]           shamt;
  logic [OUT_WIDTH-1:0] mag_c;
  s1_t                  s1_d, s1_q;
  logic [STAGES:1]      vld_pipe;

  assign exp  = floatin[30:23];
  assign frac = floatin[22:0];
  // E = exp - 127; modulo 32 that is exp[4:0] + 1. Only used for 0 <= E <= 30.
  assign shamt = exp[4:0] + 5'd1;

`ifdef FLOAT_TO_INT_ROUND_EN
  // Keep one extra bit below the binary point and add it back in.
  logic [OUT_WIDTH:0] q;
  assign q     = (OUT_WIDTH+1)'(({31'b0, 1'b1, frac} << shamt) >> 22);
  assign mag_c = q[OUT_WIDTH:1] + OUT_WIDTH'(q[0]);
`else
  assign mag_c = OUT_WIDTH'(({31'b0, 1'b1, frac} << shamt) >> 23);
`endif

  // Classify the operand and pick the integer magnitude.
  always_comb begin
    s1_d      = '0;
    s1_d.sign = floatin[31];
    if (exp == 8'd255) begin
      if (frac != 23'd0) s1_d.zero = 1'b1;
      else               s1_d.sat  = 1'b1;
    end else if (exp >= EXP_SAT) begin
      s1_d.sat = 1'b1;
    end else if (exp >= 8'd127) begin
      s1_d.mag = mag_c;
`ifdef FLOAT_TO_INT_ROUND_EN
    end else if (exp == 8'd126) begin
      // 0.5 <= |x| < 1 rounds away from zero to 1.
      s1_d.mag = OUT_WIDTH'(1);
`endif
    end else begin
      s1_d.zero = 1'b1;
    end
  end

  // Stage 1 register: classification, sign, magnitude.
  always_ff @(posedge clk) begin
    if (reset) s1_q <= '0;
    else       s1_q <= s1_d;
  end

  // Stage 2 register: saturate or apply sign. A magnitude reaching
  // 2^(OUT_WIDTH-1) (only possible after rounding) pins to MAX or MIN;
  // for negatives that equals the plain negation anyway.
  always_ff @(posedge clk) begin
    if (reset)                         intout <= '0;
    else if (s1_q.zero)                intout <= '0;
    else if (s1_q.sat || s1_q.mag[OUT_WIDTH-1])
                                       intout <= s1_q.sign ? MINV : MAXV;
    else                               intout <= s1_q.sign ? -s1_q.mag : s1_q.mag;
  end

  // Valid shift register tracking operands through both stages.
  always_ff @(posedge clk) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_float_to_int.sv
// Self-checking bench for float_to_int: directed spec vectors, a pipelining
// pattern, mid-stream reset, then randomized operands against a model.
module tb_float_to_int;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [31:0]  floatin;
  logic         out_valid;
  logic [W-1:0] intout;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] cur_exp;

  float_to_int #(.OUT_WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .floatin  (floatin),
    .out_valid(out_valid),
    .intout   (intout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: floor(2|x|) computed by plain arithmetic, then truncate or
  // round, apply sign, clamp to the signed range.
  function automatic logic [W-1:0] ref_conv(input logic [31:0] f);
    longint mx, mn, m, t2, ip, r;
    int e;
    mx = (longint'(1) << (W-1)) - 1;
    mn = -(longint'(1) << (W-1));
    e  = int'(f[30:23]) - 127;
    m  = longint'({1'b1, f[22:0]});
    if (f[30:23] == 8'd255) begin
      if (f[22:0] != 23'd0) return '0;
      return f[31] ? W'(mn) : W'(mx);
    end
    if (f[30:23] == 8'd0 || e < -1) ip = 0;
    else if (e > 34)                ip = mx + 2;
    else begin
      t2 = (m * (longint'(1) << (e + 1))) / (longint'(1) << 23);
`ifdef FLOAT_TO_INT_ROUND_EN
      ip = (t2 + 1) / 2;
`else
      ip = t2 / 2;
`endif
    end
    r = f[31] ? -ip : ip;
    if (r > mx) r = mx;
    if (r < mn) r = mn;
    return W'(r);
  endfunction

  task automatic drive(input logic v, input logic [31:0] f, input logic [W-1:0] e);
    @(negedge clk);
    in_valid = v;
    floatin  = f;
    cur_exp  = e;
  endtask

  // Latency model: expected result and valid two edges after sampling.
  logic         mv1 = 1'b0, mv2 = 1'b0;
  logic [W-1:0] md1, md2;
  logic [31:0]  mf1, mf2;
  logic         rst_seen = 1'b0, started = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mv1 = 1'b0; mv2 = 1'b0; rst_seen = 1'b1; started = 1'b1;
    end else begin
      mv2 = mv1; md2 = md1; mf2 = mf1;
      mv1 = in_valid; md1 = cur_exp; mf1 = floatin;
      rst_seen = 1'b0;
    end
    #1;
    if (started) begin
      chk("out_valid", 32'(out_valid), 32'(mv2));
      if (rst_seen)  chk("reset_intout", 32'(intout), 32'd0);
      else if (mv2)  chk($sformatf("op_%h", mf2), 32'(intout), 32'(md2));
    end
  end

  logic [31:0]  vec_in [13];
  logic [W-1:0] vec_ex [13];

  initial begin
    vec_in = '{32'h00000000, 32'h80000000, 32'h3F000000, 32'h3FC00000,
               32'hBF8CCCCD, 32'h43B5ABEE, 32'hC4AA6AFB, 32'h489E616B,
               32'hC7000000, 32'hC8000000, 32'h7F800000, 32'hFF800000,
               32'h7FC00000};
`ifdef FLOAT_TO_INT_ROUND_EN
    foreach (vec_in[i]) vec_ex[i] = ref_conv(vec_in[i]);
    vec_ex[2] = 16'h0001; vec_ex[3] = 16'h0002;
    vec_ex[4] = 16'hFFFF; vec_ex[5] = 16'h016B;
`else
    vec_ex = '{16'h0000, 16'h0000, 16'h0000, 16'h0001,
               16'hFFFF, 16'h016B, 16'hFAAD, 16'h7FFF,
               16'h8000, 16'h8000, 16'h7FFF, 16'h8000,
               16'h0000};
`endif

    reset = 1'b1; in_valid = 1'b0; floatin = '0; cur_exp = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Directed vectors back to back.
    foreach (vec_in[i]) drive(1'b1, vec_in[i], vec_ex[i]);
    drive(1'b0, 32'h0, '0);
    drive(1'b0, 32'h0, '0);

    // in_valid 1,0,1,1 on consecutive cycles.
    drive(1'b1, 32'h3FC00000, ref_conv(32'h3FC00000));
    drive(1'b0, 32'h43B5ABEE, ref_conv(32'h43B5ABEE));
    drive(1'b1, 32'hC4AA6AFB, ref_conv(32'hC4AA6AFB));
    drive(1'b1, 32'h46FFFE00, ref_conv(32'h46FFFE00));
    repeat (3) drive(1'b0, 32'h0, '0);

    // Reset with two operands in flight; nothing may emerge afterwards.
    drive(1'b1, 32'h43B5ABEE, ref_conv(32'h43B5ABEE));
    drive(1'b1, 32'hC4AA6AFB, ref_conv(32'hC4AA6AFB));
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) drive(1'b0, 32'h0, '0);

    // Randomized operands, exponent biased toward the interesting range.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] f;
      logic        v;
      f = $urandom;
      if ($urandom_range(0, 3) != 0) f[30:23] = 8'($urandom_range(120, 146));
      if ($urandom_range(0, 31) == 0) f[30:23] = 8'd255;
      if ($urandom_range(0, 31) == 0) f[30:23] = 8'd0;
      v = ($urandom_range(0, 3) != 0);
      drive(v, f, ref_conv(f));
    end
    repeat (4) drive(1'b0, 32'h0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
